oflow_bbox_packer: RTL and testbench
====================================

# oflow_bbox_packer

Rebuilds the packed bbox vector from the per-object feature set: the inverse of feature extraction. Sits at the output end of the tracking pipeline. Accepts one object's features per handshake, recomputes width and height from the top-left and bottom-right corners, and buffers packed vectors in a small FIFO. Streams them downstream with valid/ready and reports frame completion once a frame's objects have drained.

## Interface
- DEPTH, 4: FIFO entries, power of two, 2..16.
- clk  in  1  single clock, rising edge.
- reset_N  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse; opens a frame.
- frame_end  in  1  one-cycle pulse; no more objects for this frame.
- in_valid  in  1  feature set valid.
- in_ready  out  1  packer can accept.
- position_concate  in  44  {tl_x[10:0], tl_y[10:0], br_x[10:0], br_y[10:0]}.
- color1  in  24  dominant colour 1.
- color2  in  24  dominant colour 2.
- d_history  in  3  displacement history.
- out_valid  out  1  bbox_out valid.
- out_ready  in  1  downstream accepts.
- bbox_out  out  89  packed bbox vector.
- frame_done  out  1  one-cycle pulse; frame fully drained.
- geom_err  out  1  sticky geometry error, cleared on frame_start.

## Operation
- bbox layout, MSB to LSB:
  - [88:67] tl = {tl_x, tl_y}
  - [66:59] width
  - [58:51] height
  - [50:27] color1
  - [26:3] color2
  - [2:0] d_history
- Width is br_x − tl_x and height is br_y − tl_y, computed in 12-bit arithmetic. The low 8 bits are packed.
- Geometry is invalid when a difference is negative or exceeds 255.
- FSM:
  - IDLE: in_ready=0. frame_start moves to ACTIVE.
  - ACTIVE: in_ready=!full. frame_end moves to DRAIN. An object accepted in the same cycle as frame_end is kept.
  - DRAIN: in_ready=0. When the FIFO is empty, pulse frame_done and move to IDLE.
- frame_start outside IDLE is ignored.
- frame_end in IDLE is ignored.
- frame_start and frame_end in the same IDLE cycle: go to ACTIVE only; that frame_end is ignored.
- FIFO push on in_valid && in_ready. Pop on out_valid && out_ready.
- bbox_out is the FIFO head, registered, and holds stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: both occur, occupancy unchanged. Push at full cannot happen because in_ready=0.
- Pointers are log2(DEPTH) bits plus one wrap bit. Full and empty are decoded from the pointer MSB compare.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, bbox_out=0, frame_done=0, geom_err=0.
  - FSM in IDLE, pointers 0.
- Latency: an object accepted in cycle N gives out_valid=1 in N+1 if the FIFO was empty.
- Throughput: one object per cycle in each direction.
- frame_done fires one cycle after the last pop of DRAIN. If the FIFO is already empty when frame_end arrives, it fires 1 cycle after frame_end.
- in_ready is a registered function of occupancy and state; there is no combinational path from out_ready.
- Reset mid-frame discards FIFO contents immediately; no frame_done is issued.

## Configuration
- OFLOW_BBOX_PACKER_CHECK_EN defined:
  - An invalid object sets geom_err.
  - Width or height is saturated: negative gives 0, above 255 gives 255.
  - The object is still packed.
- Not defined:
  - geom_err is tied to 0.
  - Width and height are the truncated low 8 bits.
  - No compare logic is built.

## Structure
- Shared oflow package holds the field-length constants and the bbox field offsets, so feature extraction and this packer share one layout:
  - CM_LEN=11, POSITION_TL_LEN=22, POSITION_CONCATE_LEN=44
  - WIDTH_LEN=8, HEIGHT_LEN=8, COLOR_LEN=24, D_HISTORY_LEN=3
  - BBOX_VECTOR_SIZE=89
- The package also holds the FSM state enum and a bbox_t packed struct.
- One sub-module: oflow_bbox_fifo, a parameterised synchronous FIFO with registered head output.

## Test plan
- Single object:
  - Stimulus: frame_start; tl=(100,50), br=(140,80), color1=0xFF0000, color2=0x00FF00, d_history=5; out_ready=1; then frame_end.
  - Response: bbox_out={100,50,40,30,0xFF0000,0x00FF00,5} one cycle after acceptance; frame_done follows; geom_err=0.
- Backpressure:
  - Stimulus: DEPTH=4, out_ready=0, push 5 objects.
  - Response: in_ready drops after 4 accepted. Raising out_ready drains them in input order, then the 5th is accepted.
- Streaming:
  - Stimulus: push and pop every cycle for 20 objects.
  - Response: no bubbles after the first; pointers wrap cleanly; order preserved.
- Geometry error (CHECK_EN defined):
  - Stimulus: tl_x=300, br_x=200; separately br_x−tl_x=400.
  - Response: width packs as 0 and 255 respectively; geom_err=1 until the next frame_start.
- Frame control and reset:
  - Stimulus: frame_end with 3 objects queued and out_ready=0.
  - Response: frame_done only after all 3 pop.
  - Stimulus: reset_N low mid-DRAIN.
  - Response: all outputs 0, IDLE, no frame_done.

Source files
------------

// File: rtl/oflow_bbox_packer_pkg.sv
// Shared oflow bbox layout: field lengths, packed-vector offsets, packer FSM states.
// Optional geometry checking is selected by OFLOW_BBOX_PACKER_CHECK_EN.
package oflow_bbox_packer_pkg;

  localparam int CM_LEN               = 11;
  localparam int POSITION_TL_LEN      = 22;
  localparam int POSITION_CONCATE_LEN = 44;
  localparam int WIDTH_LEN            = 8;
  localparam int HEIGHT_LEN           = 8;
  localparam int COLOR_LEN            = 24;
  localparam int D_HISTORY_LEN        = 3;
  localparam int BBOX_VECTOR_SIZE     = 89;

  localparam int D_HISTORY_OFS = 0;
  localparam int COLOR2_OFS    = D_HISTORY_OFS + D_HISTORY_LEN;
  localparam int COLOR1_OFS    = COLOR2_OFS + COLOR_LEN;
  localparam int HEIGHT_OFS    = COLOR1_OFS + COLOR_LEN;
  localparam int WIDTH_OFS     = HEIGHT_OFS + HEIGHT_LEN;
  localparam int TL_OFS        = WIDTH_OFS + WIDTH_LEN;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [POSITION_TL_LEN-1:0] tl;
    logic [WIDTH_LEN-1:0]       width;
    logic [HEIGHT_LEN-1:0]      height;
    logic [COLOR_LEN-1:0]       color1;
    logic [COLOR_LEN-1:0]       color2;
    logic [D_HISTORY_LEN-1:0]   d_history;
  } bbox_t;

`ifdef OFLOW_BBOX_PACKER_CHECK_EN
  localparam int DIFF_LEN = 12;

  // Difference of two corner coordinates, saturated into the 8-bit field.
  function automatic logic [WIDTH_LEN-1:0] pack_dim(input logic [CM_LEN-1:0] lo,
                                                    input logic [CM_LEN-1:0] hi);
    logic [DIFF_LEN-1:0] d;
    d = {1'b0, hi} - {1'b0, lo};
    if (d[DIFF_LEN-1]) return '0;
    if (|d[DIFF_LEN-2:WIDTH_LEN]) return '1;
    return d[WIDTH_LEN-1:0];
  endfunction

  function automatic logic dim_bad(input logic [CM_LEN-1:0] lo,
                                   input logic [CM_LEN-1:0] hi);
    logic [DIFF_LEN-1:0] d;
    d = {1'b0, hi} - {1'b0, lo};
    return d[DIFF_LEN-1] | (|d[DIFF_LEN-2:WIDTH_LEN]);
  endfunction
`else
  function automatic logic [WIDTH_LEN-1:0] pack_dim(input logic [CM_LEN-1:0] lo,
                                                    input logic [CM_LEN-1:0] hi);
    return WIDTH_LEN'(hi - lo);
  endfunction
`endif

endpackage

// File: rtl/oflow_bbox_packer_fifo.sv
// oflow_bbox_fifo: synchronous bbox FIFO with wrap-bit pointers and a registered head.
// The head register always holds the oldest entry so it can drive bbox_out directly.
module oflow_bbox_fifo
  import oflow_bbox_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset_N,
  input  logic  push,
  input  bbox_t din,
  input  logic  pop,
  output bbox_t dout,
  output logic  dout_valid,
  output logic  full_next,
  output logic  empty_next
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("oflow_bbox_fifo: DEPTH must be a power of two in 2..16");
  end

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_next;
  logic [AW:0] rd_next;
  bbox_t       mem [DEPTH];

  assign wr_next    = wr_ptr + (AW + 1)'(push);
  assign rd_next    = rd_ptr + (AW + 1)'(pop);
  assign empty_next = (wr_next == rd_next);
  assign full_next  = (wr_next[AW] != rd_next[AW]) &&
                      (wr_next[AW-1:0] == rd_next[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // When the next head is the entry being written this cycle, bypass the array.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      dout_valid <= !empty_next;
      if (!empty_next) begin
        if (push && (rd_next == wr_ptr)) dout <= din;
        else                             dout <= mem[rd_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/oflow_bbox_packer.sv
// Packs per-object features back into the 89-bit bbox vector and streams them per frame.
// Define OFLOW_BBOX_PACKER_CHECK_EN to saturate width/height and flag bad geometry on geom_err.
//
// state     | meaning
// ST_IDLE   | between frames, no objects accepted
// ST_ACTIVE | frame open, accepting objects while FIFO has room
// ST_DRAIN  | frame closed, waiting for FIFO to empty before frame_done
module oflow_bbox_packer
  import oflow_bbox_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_N,
  input  logic                            frame_start,
  input  logic                            frame_end,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [POSITION_CONCATE_LEN-1:0] position_concate,
  input  logic [COLOR_LEN-1:0]            color1,
  input  logic [COLOR_LEN-1:0]            color2,
  input  logic [D_HISTORY_LEN-1:0]        d_history,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BBOX_VECTOR_SIZE-1:0]     bbox_out,
  output logic                            frame_done,
  output logic                            geom_err
);

  state_t                      state;
  logic                        push;
  logic                        pop;
  logic                        full_next;
  logic                        empty_next;
  logic [CM_LEN-1:0]           tl_x;
  logic [CM_LEN-1:0]           tl_y;
  logic [CM_LEN-1:0]           br_x;
  logic [CM_LEN-1:0]           br_y;
  logic [BBOX_VECTOR_SIZE-1:0] in_vec;
  bbox_t                       in_bbox;
  bbox_t                       head;

  assign tl_x = position_concate[4*CM_LEN-1 -: CM_LEN];
  assign tl_y = position_concate[3*CM_LEN-1 -: CM_LEN];
  assign br_x = position_concate[2*CM_LEN-1 -: CM_LEN];
  assign br_y = position_concate[CM_LEN-1 -: CM_LEN];

  always_comb begin
    in_vec = '0;
    in_vec[TL_OFS +: POSITION_TL_LEN]   = position_concate[POSITION_CONCATE_LEN-1 -: POSITION_TL_LEN];
    in_vec[WIDTH_OFS +: WIDTH_LEN]      = pack_dim(tl_x, br_x);
    in_vec[HEIGHT_OFS +: HEIGHT_LEN]    = pack_dim(tl_y, br_y);
    in_vec[COLOR1_OFS +: COLOR_LEN]     = color1;
    in_vec[COLOR2_OFS +: COLOR_LEN]     = color2;
    in_vec[D_HISTORY_OFS +: D_HISTORY_LEN] = d_history;
  end

  assign in_bbox  = bbox_t'(in_vec);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign bbox_out = head;

  oflow_bbox_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_N    (reset_N),
    .push       (push),
    .din        (in_bbox),
    .pop        (pop),
    .dout       (head),
    .dout_valid (out_valid),
    .full_next  (full_next),
    .empty_next (empty_next)
  );

  // in_ready is registered from next occupancy, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state    <= ST_ACTIVE;
            in_ready <= !full_next;
          end
        end
        ST_ACTIVE: begin
          if (frame_end) begin
            in_ready <= 1'b0;
            if (empty_next) begin
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            in_ready <= !full_next;
          end
        end
        ST_DRAIN: begin
          if (empty_next) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef OFLOW_BBOX_PACKER_CHECK_EN
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      geom_err <= 1'b0;
    end else if (state == ST_IDLE && frame_start) begin
      geom_err <= 1'b0;
    end else if (push && (dim_bad(tl_x, br_x) || dim_bad(tl_y, br_y))) begin
      geom_err <= 1'b1;
    end
  end
`else
  assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_oflow_bbox_packer.sv
// Self-checking bench for oflow_bbox_packer: queue-based frame model plus directed literal checks.
module tb_oflow_bbox_packer;

  localparam int DEPTH = 4;
`ifdef OFLOW_BBOX_PACKER_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_N = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [43:0] position_concate = '0;
  logic [23:0] color1 = '0;
  logic [23:0] color2 = '0;
  logic [2:0]  d_history = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [88:0] bbox_out;
  logic        frame_done;
  logic        geom_err;

  always #5 clk = ~clk;

  oflow_bbox_packer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_N          (reset_N),
    .frame_start      (frame_start),
    .frame_end        (frame_end),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .position_concate (position_concate),
    .color1           (color1),
    .color2           (color2),
    .d_history        (d_history),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .bbox_out         (bbox_out),
    .frame_done       (frame_done),
    .geom_err         (geom_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [88:0] act, input logic [88:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int dim(input int lo, input int hi);
    int d;
    d = hi - lo;
    if (CHECK) begin
      if (d < 0) d = 0;
      if (d > 255) d = 255;
    end
    return d & 255;
  endfunction

  function automatic logic [88:0] expect_bbox(input logic [43:0] pos, input logic [23:0] c1,
                                              input logic [23:0] c2, input logic [2:0] dh);
    int w;
    int h;
    logic [7:0] wb;
    logic [7:0] hb;
    w  = dim(int'(pos[43:33]), int'(pos[21:11]));
    h  = dim(int'(pos[32:22]), int'(pos[10:0]));
    wb = 8'(w);
    hb = 8'(h);
    return {pos[43:22], wb, hb, c1, c2, dh};
  endfunction

  function automatic bit is_bad(input logic [43:0] pos);
    int w;
    int h;
    w = int'(pos[21:11]) - int'(pos[43:33]);
    h = int'(pos[10:0]) - int'(pos[32:22]);
    return (w < 0) || (w > 255) || (h < 0) || (h > 255);
  endfunction

  logic [88:0] q[$];
  int          mode;          // 0 idle, 1 frame open, 2 waiting for drain
  bit          m_in_ready;
  bit          m_out_valid;
  bit          m_done;
  bit          m_err;
  bit          m_push;
  bit          m_pop;

  always @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      q.delete();
      mode        = 0;
      m_in_ready  = 0;
      m_out_valid = 0;
      m_done      = 0;
      m_err       = 0;
    end else begin
      m_push = in_valid && m_in_ready;
      m_pop  = m_out_valid && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(expect_bbox(position_concate, color1, color2, d_history));
      m_done = 0;
      case (mode)
        0: if (frame_start) begin mode = 1; m_err = 0; end
        1: if (frame_end) begin
             if (q.size() == 0) begin mode = 0; m_done = 1; end
             else mode = 2;
           end
        default: if (q.size() == 0) begin mode = 0; m_done = 1; end
      endcase
      if (CHECK && m_push && is_bad(position_concate)) m_err = 1;
      m_in_ready  = (mode == 1) && (q.size() < DEPTH);
      m_out_valid = (q.size() != 0);
    end
  end

  always @(negedge clk) begin
    chk1("in_ready", in_ready, m_in_ready);
    chk1("out_valid", out_valid, m_out_valid);
    chk1("frame_done", frame_done, m_done);
    chk1("geom_err", geom_err, m_err);
    if (m_out_valid) chkv("bbox_out", bbox_out, q[0]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obj(input int tlx, input int tly, input int brx, input int bry,
                         input logic [23:0] c1, input logic [23:0] c2, input logic [2:0] dh);
    position_concate = {11'(tlx), 11'(tly), 11'(brx), 11'(bry)};
    color1    = c1;
    color2    = c2;
    d_history = dh;
  endtask

  task automatic rand_obj(input bit allow_bad);
    int tlx;
    int tly;
    int brx;
    int bry;
    tlx = $urandom_range(0, 1700);
    tly = $urandom_range(0, 1700);
    brx = tlx + $urandom_range(0, 255);
    bry = tly + $urandom_range(0, 255);
    if (allow_bad && ($urandom_range(0, 3) == 0)) brx = $urandom_range(0, 2047);
    if (allow_bad && ($urandom_range(0, 3) == 0)) bry = $urandom_range(0, 2047);
    set_obj(tlx, tly, brx, bry, 24'($urandom), 24'($urandom), 3'($urandom));
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin cyc(); k++; end
    if (!in_ready) chk1(name, in_ready, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!frame_done && k < 40) begin cyc(); k++; end
    chk1(name, frame_done, 1'b1);
  endtask

  task automatic open_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic push_one(input string name);
    in_valid = 1'b1;
    wait_ready(name);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic close_frame(input string name);
    frame_end = 1'b1;
    cyc();
    frame_end = 1'b0;
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [88:0] lit;
    int stalls;
    int pops;
    int k;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkv("rst_bbox", bbox_out, '0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk1("rst_geom_err", geom_err, 1'b0);
    reset_N = 1'b1;
    cyc();

    // single object
    open_frame();
    out_ready = 1'b1;
    set_obj(100, 50, 140, 80, 24'hFF0000, 24'h00FF00, 3'd5);
    push_one("single_ready");
    lit = {11'd100, 11'd50, 8'd40, 8'd30, 24'hFF0000, 24'h00FF00, 3'd5};
    chk1("single_valid", out_valid, 1'b1);
    chkv("single_bbox", bbox_out, lit);
    close_frame("single_done");
    chk1("single_geom_err", geom_err, 1'b0);
    cyc();

    // backpressure
    open_frame();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_obj(1'b0);
      push_one("bp_ready");
    end
    chk1("bp_full_ready", in_ready, 1'b0);
    rand_obj(1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("bp_blocked", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    wait_ready("bp_fifth");
    cyc();
    in_valid = 1'b0;
    close_frame("bp_done");
    cyc();

    // streaming
    open_frame();
    out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      rand_obj(1'b0);
      in_valid = 1'b1;
      if (!in_ready) stalls++;
      if (i > 0) chk1("stream_no_bubble", out_valid, 1'b1);
      wait_ready("stream_ready");
      cyc();
    end
    in_valid = 1'b0;
    chki("stream_stalls", stalls, 0);
    close_frame("stream_done");
    cyc();

    // geometry
    open_frame();
    out_ready = 1'b1;
    set_obj(300, 10, 200, 20, 24'h123456, 24'h654321, 3'd1);
    push_one("geo1_ready");
    chki("geo_neg_width", int'(bbox_out[66:59]), CHECK ? 0 : 156);
    chk1("geo_err_set", geom_err, CHECK);
    set_obj(100, 10, 500, 20, 24'h111111, 24'h222222, 3'd2);
    push_one("geo2_ready");
    chki("geo_big_width", int'(bbox_out[66:59]), CHECK ? 255 : 144);
    close_frame("geo_done");
    chk1("geo_err_sticky", geom_err, CHECK);
    open_frame();
    chk1("geo_err_cleared", geom_err, 1'b0);

    // frame_end with 3 queued objects and no downstream ready
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_obj(1'b0);
      push_one("fc_ready");
    end
    frame_end = 1'b1;
    cyc();
    frame_end = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk1("fc_no_early_done", frame_done, 1'b0);
      cyc();
    end
    out_ready = 1'b1;
    pops = 0;
    k = 0;
    while (!frame_done && k < 30) begin
      if (out_valid) pops++;
      cyc();
      k++;
    end
    chk1("fc_done", frame_done, 1'b1);
    chki("fc_pops", pops, 3);
    cyc();

    // reset mid-DRAIN
    open_frame();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_obj(1'b0);
      push_one("rst_push");
    end
    frame_end = 1'b1;
    cyc();
    frame_end = 1'b0;
    cyc();
    reset_N = 1'b0;
    #1;
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chkv("mid_rst_bbox", bbox_out, '0);
    chk1("mid_rst_frame_done", frame_done, 1'b0);
    chk1("mid_rst_geom_err", geom_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk1("post_rst_no_done", frame_done, 1'b0);
      chk1("post_rst_in_ready", in_ready, 1'b0);
    end

    // randomized traffic, including misplaced and coincident frame pulses
    for (int i = 0; i < 800; i++) begin
      frame_start = ($urandom_range(0, 15) == 0);
      frame_end   = ($urandom_range(0, 11) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      rand_obj(1'b1);
      cyc();
    end
    frame_start = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    frame_end   = 1'b1;
    cyc();
    frame_end = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
